alu_sequencer: RTL and testbench

- Multi-cycle control unit for the S-Machine ALU: fetches 16-bit instructions, reads the register-file operands, presents them to the combinational ALU, then writes back registers and the Z/N/C status word.
- Sits between instruction memory, the 8-entry register file and the ALU; owns the PC and the PSW flag register.
- The ALU re-evaluates only when its instruction input changes. alu_inst is therefore forced to 16'h0000 while operands settle, then switched to the real instruction.

---
 rtl/alu_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/read/exec/writeback control for the
// S-Machine ALU. Owns the PC and the {Z,N,C} status word.
// Optional build macro ALU_SEQ_STEP_EN adds a `step` input and single-step mode
// (the FSM returns to IDLE after every writeback).
module alu_sequencer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef ALU_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [2:0]        rf_raddr_a,
    output logic [2:0]        rf_raddr_b,
    input  logic [15:0]       rf_rdata_a,
    input  logic [15:0]       rf_rdata_b,
    output logic              rf_we_a,
    output logic              rf_we_b,
    output logic [2:0]        rf_waddr_a,
    output logic [2:0]        rf_waddr_b,
    output logic [15:0]       rf_wdata_a,
    output logic [15:0]       rf_wdata_b,
    output logic [15:0]       alu_inst,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    input  logic [15:0]       alu_a_res,
    input  logic [15:0]       alu_b_res,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    output logic [2:0]        psw,
    output logic              busy,
    output logic              halted,
    output logic              illegal_op
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ILL1 = 4'h1;
    localparam logic [OP_W-1:0] OP_INC  = 4'h2;
    localparam logic [OP_W-1:0] OP_ILL3 = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
    localparam logic [OP_W-1:0] OP_OR   = 4'h6;
    localparam logic [OP_W-1:0] OP_AND  = 4'h7;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h9;
    localparam logic [OP_W-1:0] OP_MOV  = 4'hA;
    localparam logic [OP_W-1:0] OP_EXCH = 4'hB;
    localparam logic [OP_W-1:0] OP_CMP  = 4'hC;
    localparam logic [OP_W-1:0] OP_SET  = 4'hD;
    localparam logic [OP_W-1:0] OP_CLR  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [OP_W-1:0]   op;
    logic              go_c;
    logic              in_wb;

    logic              wb_we_a_c;
    logic              wb_we_b_c;
    logic [2:0]        wb_waddr_a_c;
    logic [2:0]        wb_waddr_b_c;
    logic              wb_psw_we_c;
    logic              wb_illegal_c;

    assign op       = ir[15:12];
    assign in_wb    = (state == S_WB);
    assign mem_addr = pc;

`ifdef ALU_SEQ_STEP_EN
    assign go_c = start | step;
    localparam state_t WB_NEXT = S_IDLE;
`else
    assign go_c = start;
    localparam state_t WB_NEXT = S_FETCH;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE/HALTED
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (go_c) state_next = S_FETCH;
            S_FETCH:  if (mem_ack) state_next = S_DECODE;
            S_DECODE: state_next = S_READ;
            S_READ:   state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = (op == OP_HALT) ? S_HALTED : WB_NEXT;
            S_HALTED: if (go_c) state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Writeback decode: which ports write, whether flags update, illegal opcodes
    always_comb begin
        wb_we_a_c    = 1'b0;
        wb_we_b_c    = 1'b0;
        wb_waddr_a_c = ir[5:3];
        wb_waddr_b_c = ir[2:0];
        wb_psw_we_c  = 1'b0;
        wb_illegal_c = 1'b0;
        case (op)
            OP_INC: begin
                wb_waddr_a_c = ir[10:8];
                wb_waddr_b_c = ir[10:8];
                wb_we_a_c    = ~ir[11];
                wb_we_b_c    = ir[11];
                wb_psw_we_c  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR: begin
                wb_we_a_c   = 1'b1;
                wb_psw_we_c = 1'b1;
            end
            OP_MOV: begin
                wb_we_b_c   = 1'b1;
                wb_psw_we_c = 1'b1;
            end
            OP_EXCH: begin
                wb_we_a_c   = 1'b1;
                wb_we_b_c   = 1'b1;
                wb_psw_we_c = 1'b1;
            end
            OP_CMP, OP_SET, OP_CLR: begin
                wb_psw_we_c = 1'b1;
            end
            OP_ILL1, OP_ILL3: begin
                wb_illegal_c = 1'b1;
            end
            OP_NOP, OP_HALT: begin
                wb_psw_we_c = 1'b0;
            end
            default: begin
                wb_psw_we_c = 1'b0;
            end
        endcase
    end

    // Fetch, operand read and ALU presentation; alu_inst stays 0 until operands settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ir         <= '0;
            mem_req    <= 1'b0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            alu_inst   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            mem_req <= (state_next == S_FETCH);
            if (state == S_FETCH && mem_ack) begin
                ir <= mem_rdata;
                pc <= pc + ADDR_W'(1);
                if (mem_rdata[15:12] == OP_INC) begin
                    rf_raddr_a <= mem_rdata[10:8];
                    rf_raddr_b <= mem_rdata[10:8];
                end else begin
                    rf_raddr_a <= mem_rdata[5:3];
                    rf_raddr_b <= mem_rdata[2:0];
                end
            end
            if (state == S_READ) begin
                alu_a <= rf_rdata_a;
                alu_b <= rf_rdata_b;
            end
            alu_inst <= (state_next == S_EXEC || state_next == S_WB) ? ir : 16'h0000;
        end
    end

    // Writeback strobes, status word and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_a    <= 1'b0;
            rf_we_b    <= 1'b0;
            rf_waddr_a <= '0;
            rf_waddr_b <= '0;
            rf_wdata_a <= '0;
            rf_wdata_b <= '0;
            psw        <= '0;
            illegal_op <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            rf_we_a    <= in_wb && wb_we_a_c;
            rf_we_b    <= in_wb && wb_we_b_c;
            illegal_op <= in_wb && wb_illegal_c;
            if (in_wb && wb_we_a_c) begin
                rf_waddr_a <= wb_waddr_a_c;
                rf_wdata_a <= alu_a_res;
            end
            if (in_wb && wb_we_b_c) begin
                rf_waddr_b <= wb_waddr_b_c;
                rf_wdata_b <= alu_b_res;
            end
            if (in_wb && wb_psw_we_c) begin
                psw <= {alu_z, alu_n, alu_c};
            end
            busy   <= !(state_next == S_IDLE || state_next == S_HALTED);
            halted <= (state_next == S_HALTED);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instruction memory, register file and ALU
// are modelled here; a second instance checks PC wrap from 0xFFFF.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  rf_raddr_a, rf_raddr_b;
    logic [15:0] rf_rdata_a, rf_rdata_b;
    logic        rf_we_a, rf_we_b;
    logic [2:0]  rf_waddr_a, rf_waddr_b;
    logic [15:0] rf_wdata_a, rf_wdata_b;
    logic [15:0] alu_inst, alu_a, alu_b;
    logic [15:0] alu_a_res, alu_b_res;
    logic        alu_z, alu_n, alu_c;
    logic [2:0]  psw;
    logic        busy, halted, illegal_op;

    // second instance, RESET_PC = 0xFFFF, fed NOPs
    logic        start2;
    logic        mem_req2, mem_ack2;
    logic [15:0] mem_addr2;
    logic [15:0] zero16;
    logic        zero1;
    logic [2:0]  raddr2_a, raddr2_b, waddr2_a, waddr2_b;
    logic        we2_a, we2_b, busy2, halted2, ill2;
    logic [15:0] wdata2_a, wdata2_b, inst2, a2, b2;
    logic [2:0]  psw2;

    logic [15:0] imem [16];
    logic [15:0] regs [8];
    int          ack_dly;
    int          wait_cnt;
    logic        ack_force;

    int n_total;
    int n_pass;
    int n_fail;

    alu_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we_a(rf_we_a), .rf_we_b(rf_we_b),
        .rf_waddr_a(rf_waddr_a), .rf_waddr_b(rf_waddr_b),
        .rf_wdata_a(rf_wdata_a), .rf_wdata_b(rf_wdata_b),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
        .alu_a_res(alu_a_res), .alu_b_res(alu_b_res),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .psw(psw), .busy(busy), .halted(halted), .illegal_op(illegal_op)
    );

    alu_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(zero16),
        .rf_raddr_a(raddr2_a), .rf_raddr_b(raddr2_b),
        .rf_rdata_a(zero16), .rf_rdata_b(zero16),
        .rf_we_a(we2_a), .rf_we_b(we2_b),
        .rf_waddr_a(waddr2_a), .rf_waddr_b(waddr2_b),
        .rf_wdata_a(wdata2_a), .rf_wdata_b(wdata2_b),
        .alu_inst(inst2), .alu_a(a2), .alu_b(b2),
        .alu_a_res(zero16), .alu_b_res(zero16),
        .alu_z(zero1), .alu_n(zero1), .alu_c(zero1),
        .psw(psw2), .busy(busy2), .halted(halted2), .illegal_op(ill2)
    );

    assign zero16 = 16'h0000;
    assign zero1  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: ack after ack_dly extra FETCH cycles
    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cnt >= ack_dly) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack  = ack_force;
            wait_cnt = 0;
        end
        mem_rdata = imem[mem_addr[3:0]];
    end

    always @(negedge clk) mem_ack2 = mem_req2;

    // register file: one-cycle read latency, port A wins on same-index write
    always @(posedge clk) begin
        rf_rdata_a <= regs[rf_raddr_a];
        rf_rdata_b <= regs[rf_raddr_b];
        if (!rst_n) begin
            regs[0] <= 16'h0000; regs[1] <= 16'h0003;
            regs[2] <= 16'h0005; regs[3] <= 16'h00FF;
            regs[4] <= 16'h00FF; regs[5] <= 16'h1234;
            regs[6] <= 16'hABCD; regs[7] <= 16'h7FFF;
        end else begin
            if (rf_we_b) regs[rf_waddr_b] <= rf_wdata_b;
            if (rf_we_a) regs[rf_waddr_a] <= rf_wdata_a;
        end
    end

    // ALU model
    always_comb begin
        logic [16:0] t;
        logic [15:0] r;
        logic        cy;
        logic        use_psw;
        t = 17'h0; r = 16'h0; cy = 1'b0; use_psw = 1'b0;
        alu_a_res = 16'h0; alu_b_res = 16'h0;
        case (alu_inst[15:12])
            4'h2: begin
                t = alu_inst[11] ? ({1'b0, alu_b} + 17'd1) : ({1'b0, alu_a} + 17'd1);
                r = t[15:0]; cy = t[16];
                alu_a_res = alu_a + 16'd1; alu_b_res = alu_b + 16'd1;
            end
            4'h4: begin t = {1'b0, alu_a} + {1'b0, alu_b}; r = t[15:0]; cy = t[16]; alu_a_res = r; end
            4'h5, 4'hC: begin t = {1'b0, alu_a} - {1'b0, alu_b}; r = t[15:0]; cy = t[16]; alu_a_res = r; end
            4'h6: begin r = alu_a | alu_b; alu_a_res = r; end
            4'h7: begin r = alu_a & alu_b; alu_a_res = r; end
            4'h8: begin r = alu_a ^ alu_b; alu_a_res = r; end
            4'h9: begin r = alu_a >> 1; cy = alu_a[0]; alu_a_res = r; end
            4'hA: begin alu_b_res = alu_a; use_psw = 1'b1; end
            4'hB: begin alu_a_res = alu_b; alu_b_res = alu_a; use_psw = 1'b1; end
            default: use_psw = 1'b1;
        endcase
        if (alu_inst[15:12] == 4'hD) begin
            {alu_z, alu_n, alu_c} = psw | alu_inst[10:8];
        end else if (alu_inst[15:12] == 4'hE) begin
            {alu_z, alu_n, alu_c} = psw & ~alu_inst[10:8];
        end else if (use_psw) begin
            {alu_z, alu_n, alu_c} = psw;
        end else begin
            {alu_z, alu_n, alu_c} = {(r == 16'h0), r[15], cy};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] wbv(input logic wa_en, input logic [2:0] wa, input logic [15:0] da,
                                        input logic wb_en, input logic [2:0] wb, input logic [15:0] db,
                                        input logic ill, input logic [2:0] p);
        return {wa_en, wa_en ? wa : 3'd0, wa_en ? da : 16'd0,
                wb_en, wb_en ? wb : 3'd0, wb_en ? db : 16'd0, ill, p};
    endfunction

    // Runs one instruction from the FETCH cycle through the cycle after WB
    task automatic run_instr(input string tag, input logic [15:0] exp_addr, input logic [15:0] instr,
                             input int exp_fetch, input logic [43:0] exp_wb, input bit poke);
        int  n;
        bit  stable;
        bit  got;
        n = 0; stable = 1'b1; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            n++;
            if (!(mem_req === 1'b1 && mem_addr === exp_addr)) stable = 1'b0;
            if (mem_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " fetch_hold"}, 64'(stable), 64'(1));
        chk({tag, " fetch_cycles"}, 64'(got ? n : 0), 64'(exp_fetch));
        @(posedge clk); #1;
        chk({tag, " decode_quiet"}, 64'({alu_inst, illegal_op, rf_we_a, rf_we_b, mem_req}), 64'(0));
        if (poke) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end else begin
            @(posedge clk);
        end
        @(posedge clk); #1;
        chk({tag, " exec_inst"}, 64'(alu_inst), 64'(instr));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " writeback"},
            64'(wbv(rf_we_a, rf_waddr_a, rf_wdata_a, rf_we_b, rf_waddr_b, rf_wdata_b, illegal_op, psw)),
            64'(exp_wb));
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        ack_dly = 0; ack_force = 1'b0; wait_cnt = 0;
        mem_ack = 1'b0; mem_rdata = 16'h0; mem_ack2 = 1'b0;
        imem[0] = 16'h400A;  // ADD R1,R2
        imem[1] = 16'hD200;  // SET N
        imem[2] = 16'hB02E;  // EXCH R5,R6
        imem[3] = 16'hC01C;  // CMP R3,R4
        imem[4] = 16'hE400;  // CLR Z
        imem[5] = 16'h1000;  // undefined
        imem[6] = 16'h2F00;  // INC R7 via port B
        imem[7] = 16'hF000;  // HALT
        for (int i = 8; i < 16; i++) imem[i] = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("reset_status", 64'({busy, halted, mem_req, illegal_op, psw}), 64'(0));
        chk("reset_addr", 64'(mem_addr), 64'(16'h0000));
        chk("reset_alu", 64'({alu_inst, alu_a, alu_b}), 64'(0));
        chk("reset_rf", 64'({rf_we_a, rf_we_b, rf_waddr_a, rf_wdata_a, rf_raddr_a, rf_raddr_b}), 64'(0));

        // PC wrap on the RESET_PC=0xFFFF instance
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        #1;
        chk("wrap_first_fetch", 64'({mem_req2, mem_addr2}), 64'({1'b1, 16'hFFFF}));
        @(posedge clk); #1;
        chk("wrap_next_addr", 64'(mem_addr2), 64'(16'h0000));

        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_fetch", 64'({mem_req, busy, mem_addr}), 64'({1'b1, 1'b1, 16'h0000}));

        run_instr("add", 16'd0, 16'h400A, 1, wbv(1, 3'd1, 16'h0008, 0, 3'd0, 16'h0, 0, 3'b000), 0);
        run_instr("set_n", 16'd1, 16'hD200, 1, wbv(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'b010), 0);
        run_instr("exch", 16'd2, 16'hB02E, 1, wbv(1, 3'd5, 16'hABCD, 1, 3'd6, 16'h1234, 0, 3'b010), 0);
        run_instr("cmp_eq", 16'd3, 16'hC01C, 1, wbv(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'b100), 1);
        run_instr("clr_z", 16'd4, 16'hE400, 1, wbv(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'b000), 0);
        ack_dly = 3;
        run_instr("illegal", 16'd5, 16'h1000, 4, wbv(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'b000), 0);
        ack_dly = 0;
        run_instr("inc_b", 16'd6, 16'h2F00, 1, wbv(0, 3'd0, 16'h0, 1, 3'd7, 16'h8000, 0, 3'b010), 0);
        run_instr("halt", 16'd7, 16'hF000, 1, wbv(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'b010), 0);
        chk("halted_state", 64'({halted, busy, mem_req}), 64'(3'b100));
        repeat (3) @(posedge clk);
        #1;
        chk("halted_stays", 64'({halted, busy, mem_req, mem_addr}), 64'({3'b100, 16'd8}));
        chk("rf_after_run", 64'({regs[1], regs[5], regs[6], regs[7]}),
            64'({16'h0008, 16'hABCD, 16'h1234, 16'h8000}));

        // restart from HALTED, then reset in the middle of the fetch
        ack_dly = 10;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        #1;
        chk("resume_fetch", 64'({mem_req, busy, halted, mem_addr}), 64'({3'b110, 16'd8}));
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({mem_req, busy, psw, mem_addr}), 64'({2'b00, 3'b000, 16'h0000}));
        @(negedge clk) rst_n = 1'b1;
        ack_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ack_force = 1'b0;
        chk("stale_ack_ignored", 64'({mem_req, busy, halted, mem_addr}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
